cdb_writeback_arbiter: RTL

- Shares the single common data bus (CDB) between the EXECUTION_LANES execution lanes fed by the issue stage's reservation-station demux.
- Each lane presents a finished result: ROB index plus data. The arbiter grants one lane per cycle using round-robin priority.
- The granted result is registered into a one-entry output stage that drives the ROB writeback port and the reservation-station wakeup broadcast.
- A ROB flush discards both the pending output and any grant made in the same cycle.

---
 rtl/cdb_writeback_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/cdb_writeback_arbiter.sv
// Round-robin writeback arbiter: grants one execution lane per cycle onto the
// common data bus through a one-entry output register with backpressure and flush.
module cdb_writeback_arbiter #(
  parameter int unsigned XLEN             = 64,
  parameter int unsigned ROB_INDEX_WIDTH  = 8,
  parameter int unsigned EXECUTION_LANES  = 3,
  parameter int unsigned LANE_INDEX_WIDTH = 2
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [EXECUTION_LANES-1:0]                 lane_valid,
  output logic [EXECUTION_LANES-1:0]                 lane_ready,
  input  logic [EXECUTION_LANES*ROB_INDEX_WIDTH-1:0] lane_ROB_index,
  input  logic [EXECUTION_LANES*XLEN-1:0]            lane_data,
  output logic                                       cdb_valid,
  input  logic                                       cdb_ready,
  output logic [ROB_INDEX_WIDTH-1:0]                 cdb_ROB_index,
  output logic [XLEN-1:0]                            cdb_data,
  output logic [LANE_INDEX_WIDTH-1:0]                cdb_lane,
  input  logic                                       flush
);

  logic                        valid_q, valid_d;
  logic [ROB_INDEX_WIDTH-1:0]  rob_q, rob_d;
  logic [XLEN-1:0]             data_q, data_d;
  logic [LANE_INDEX_WIDTH-1:0] lane_q, lane_d;
  logic [LANE_INDEX_WIDTH-1:0] ptr_q, ptr_d;

  logic                        load_en;
  logic                        grant_found;
  logic [LANE_INDEX_WIDTH-1:0] grant_idx;
  logic [EXECUTION_LANES-1:0]  shifted;
  int unsigned                 cand;
  int unsigned                 next_ptr;

  always_comb begin
    load_en     = !flush && (!valid_q || cdb_ready);
    grant_found = 1'b0;
    grant_idx   = '0;
    shifted     = '0;
    cand        = 0;
    // Scan lanes starting at the pointer; candidates wrap so only real lanes are visited.
    for (int unsigned k = 0; k < EXECUTION_LANES; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= EXECUTION_LANES) begin
        cand = cand - EXECUTION_LANES;
      end
      shifted = lane_valid >> cand;
      if (!grant_found && shifted[0]) begin
        grant_found = 1'b1;
        grant_idx   = LANE_INDEX_WIDTH'(cand);
      end
    end

    lane_ready = '0;
    if (grant_found && load_en && !reset) begin
      lane_ready = EXECUTION_LANES'(1) << grant_idx;
    end

    next_ptr = 32'(grant_idx) + 1;
    if (next_ptr >= EXECUTION_LANES) begin
      next_ptr = 0;
    end

    valid_d = valid_q;
    rob_d   = rob_q;
    data_d  = data_q;
    lane_d  = lane_q;
    ptr_d   = ptr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_en) begin
      valid_d = grant_found;
      if (grant_found) begin
        rob_d  = ROB_INDEX_WIDTH'(lane_ROB_index >> (32'(grant_idx) * ROB_INDEX_WIDTH));
        data_d = XLEN'(lane_data >> (32'(grant_idx) * XLEN));
        lane_d = grant_idx;
        ptr_d  = LANE_INDEX_WIDTH'(next_ptr);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      rob_q   <= '0;
      data_q  <= '0;
      lane_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rob_q   <= rob_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      ptr_q   <= ptr_d;
    end
  end

  assign cdb_valid     = valid_q;
  assign cdb_ROB_index = rob_q;
  assign cdb_data      = data_q;
  assign cdb_lane      = lane_q;

endmodule
